// File: rtl/blinker_pkg.sv
// Shared definitions for the digit blink engine: per-group mode codes,
// the mode field width, and the mode-to-visibility decode helper.
package blinker_pkg;

    localparam int BLINK_MODE_W = 2;

    typedef enum logic [BLINK_MODE_W-1:0] {
        BLINK_MODE_STEADY = 2'b00,
        BLINK_MODE_BLINK  = 2'b01,
        BLINK_MODE_OFF    = 2'b10,
        BLINK_MODE_FAST   = 2'b11
    } blink_mode_e;

    // Visibility of one group for the current phase windows.
    function automatic logic mode_lit(
        input blink_mode_e m,
        input logic        slow_on,
        input logic        fast_on
    );
        logic lit;
        lit = 1'b0;
        unique case (m)
            BLINK_MODE_STEADY: lit = 1'b1;
            BLINK_MODE_BLINK:  lit = slow_on;
            BLINK_MODE_OFF:    lit = 1'b0;
            BLINK_MODE_FAST:   lit = fast_on;
        endcase
        return lit;
    endfunction

endpackage

// File: rtl/blink_phase_gen.sv
// Blink phase counter: advances on tick_en, restarts on kick, and derives
// the slow and fast visibility windows from the current phase.
// Ports: clk, reset_n (async, active-low), tick_en, kick -> slow_on, fast_on.
// Macro BLINK_ENGINE_FAST_MODE_EN builds the double-rate window; without it
// fast_on simply follows slow_on so FAST behaves as BLINK.
module blink_phase_gen #(
    parameter  int PERIOD_TICKS = 8,
    parameter  int ON_TICKS     = 4,
    localparam int PH_W         = $clog2(PERIOD_TICKS)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tick_en,
    input  logic kick,
    output logic slow_on,
    output logic fast_on
);
    import blinker_pkg::*;

    localparam logic [PH_W-1:0] PH_ONE  = PH_W'(1);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(PERIOD_TICKS - 1);
    localparam logic [PH_W-1:0] ON_LIM  = PH_W'(ON_TICKS);

    logic [PH_W-1:0] ph;

    // kick wins over tick_en so a restart never loses to a coincident tick
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ph <= '0;
        end else if (kick) begin
            ph <= '0;
        end else if (tick_en) begin
            ph <= (ph == PH_LAST) ? '0 : ph + PH_ONE;
        end
    end

    assign slow_on = (ph < ON_LIM);

`ifdef BLINK_ENGINE_FAST_MODE_EN
    localparam logic [PH_W-1:0] HALF    = PH_W'(PERIOD_TICKS / 2);
    localparam logic [PH_W-1:0] FAST_ON = PH_W'(ON_TICKS / 2);

    // ph never reaches PERIOD_TICKS, so one conditional subtract is the
    // full modulo by half a period
    logic [PH_W-1:0] ph_half;

    assign ph_half = (ph >= HALF) ? ph - HALF : ph;
    assign fast_on = (ph_half < FAST_ON);
`else
    assign fast_on = slow_on;
`endif

endmodule

// File: rtl/blink_engine.sv
// Grouped digit blink engine: per-group mode (steady/blink/off/fast) drives
// a registered per-digit enable mask plus a registered slow-phase flag.
// Ports: clk, reset_n (async, active-low), tick_en, kick,
//        mode[2*NUM_GROUPS-1:0] -> digit_en[NUM_DIGITS-1:0], blink_phase.
// Macro BLINK_ENGINE_FAST_MODE_EN enables the FAST mode window; otherwise
// mode 11 behaves like BLINK.
module blink_engine #(
    parameter  int NUM_DIGITS   = 6,
    parameter  int GROUP_SIZE   = 2,
    parameter  int PERIOD_TICKS = 8,
    parameter  int ON_TICKS     = 4,
    localparam int NUM_GROUPS   = NUM_DIGITS / GROUP_SIZE
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    tick_en,
    input  logic                    kick,
    input  logic [2*NUM_GROUPS-1:0] mode,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    blink_phase
);
    import blinker_pkg::*;

    if (NUM_DIGITS % GROUP_SIZE != 0) begin : g_bad_group
        $error("blink_engine: NUM_DIGITS must be a multiple of GROUP_SIZE");
    end
    if ((PERIOD_TICKS % 2 != 0) || (ON_TICKS % 2 != 0)) begin : g_bad_even
        $error("blink_engine: PERIOD_TICKS and ON_TICKS must be even");
    end
    if (ON_TICKS >= PERIOD_TICKS) begin : g_bad_on
        $error("blink_engine: ON_TICKS must be below PERIOD_TICKS");
    end
    if ((PERIOD_TICKS < 4) || (ON_TICKS < 2)) begin : g_bad_min
        $error("blink_engine: PERIOD_TICKS >= 4 and ON_TICKS >= 2 required");
    end

    logic                  slow_on;
    logic                  fast_on;
    logic [NUM_GROUPS-1:0] group_lit;
    logic [NUM_DIGITS-1:0] digit_nxt;

    blink_phase_gen #(
        .PERIOD_TICKS (PERIOD_TICKS),
        .ON_TICKS     (ON_TICKS)
    ) u_phase (
        .clk     (clk),
        .reset_n (reset_n),
        .tick_en (tick_en),
        .kick    (kick),
        .slow_on (slow_on),
        .fast_on (fast_on)
    );

    always_comb begin
        group_lit = '0;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            group_lit[g] = mode_lit(
                blink_mode_e'(mode[BLINK_MODE_W*g +: BLINK_MODE_W]),
                slow_on, fast_on);
        end
    end

    always_comb begin
        digit_nxt = '0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            digit_nxt[d] = group_lit[d / GROUP_SIZE];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            digit_en    <= '0;
            blink_phase <= 1'b0;
        end else begin
            digit_en    <= digit_nxt;
            blink_phase <= slow_on;
        end
    end

endmodule

// File: tb/tb_blink_engine.sv
// Self-checking bench for blink_engine: default instance plus a
// 4-digit/1-per-group/6-tick sweep instance, checked against a phase model.
module tb_blink_engine;

    logic       clk;
    logic       reset_n;
    logic       tick_en;
    logic       kick;
    logic [5:0] mode_a;
    logic [7:0] mode_b;
    logic [5:0] digit_en_a;
    logic [3:0] digit_en_b;
    logic       blink_phase_a;
    logic       blink_phase_b;

    int errors = 0;
    int checks = 0;

    blink_engine u_a (
        .clk         (clk),
        .reset_n     (reset_n),
        .tick_en     (tick_en),
        .kick        (kick),
        .mode        (mode_a),
        .digit_en    (digit_en_a),
        .blink_phase (blink_phase_a)
    );

    blink_engine #(
        .NUM_DIGITS   (4),
        .GROUP_SIZE   (1),
        .PERIOD_TICKS (6),
        .ON_TICKS     (2)
    ) u_b (
        .clk         (clk),
        .reset_n     (reset_n),
        .tick_en     (tick_en),
        .kick        (kick),
        .mode        (mode_b),
        .digit_en    (digit_en_b),
        .blink_phase (blink_phase_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    // Visibility of a group with mode m at phase ph of a p-tick period.
    function automatic logic lit(input logic [1:0] m, input int ph,
                                 input int p, input int on);
        case (m)
            2'b00:   return 1'b1;
            2'b01:   return ph < on;
            2'b10:   return 1'b0;
            default: begin
`ifdef BLINK_ENGINE_FAST_MODE_EN
                return (ph % (p / 2)) < (on / 2);
`else
                return ph < on;
`endif
            end
        endcase
    endfunction

    function automatic logic [7:0] digits(input logic [7:0] m, input int ph,
                                          input int nd, input int gs,
                                          input int p, input int on);
        logic [7:0] r;
        r = '0;
        for (int d = 0; d < nd; d++) begin
            r[d] = lit(m[2*(d/gs) +: 2], ph, p, on);
        end
        return r;
    endfunction

    // Model: outputs after an edge come from the mode at that edge and the
    // phase held before it; the phase then counts ticks since the last kick.
    int         ph_a = 0;
    int         ph_b = 0;
    logic [7:0] ea = '0;
    logic [7:0] eb = '0;
    logic       pa = 1'b0;
    logic       pb = 1'b0;

    always @(posedge clk) begin
        if (!reset_n) begin
            ph_a = 0; ph_b = 0;
            ea = '0; eb = '0; pa = 1'b0; pb = 1'b0;
        end else begin
            ea = digits({2'b00, mode_a}, ph_a, 6, 2, 8, 4);
            eb = digits(mode_b, ph_b, 4, 1, 6, 2);
            pa = (ph_a < 4);
            pb = (ph_b < 2);
            if (kick) begin
                ph_a = 0; ph_b = 0;
            end else if (tick_en) begin
                ph_a = (ph_a + 1) % 8;
                ph_b = (ph_b + 1) % 6;
            end
        end
        #1;
        chk("model_digit_en_a", {2'b00, digit_en_a}, ea);
        chk("model_phase_a", {7'b0, blink_phase_a}, {7'b0, pa});
        chk("model_digit_en_b", {4'b0, digit_en_b}, eb);
        chk("model_phase_b", {7'b0, blink_phase_b}, {7'b0, pb});
    end

    task automatic cyc(input logic t, input logic k);
        tick_en = t;
        kick    = k;
        @(negedge clk);
    endtask

    task automatic pulse();
        cyc(1'b1, 1'b0);
        repeat (3) cyc(1'b0, 1'b0);
    endtask

    initial begin
        reset_n = 1'b0;
        tick_en = 1'b0;
        kick    = 1'b0;
        mode_a  = 6'b00_00_00;
        mode_b  = 8'h55;
        repeat (3) @(negedge clk);
        chk("reset_digits_a", {2'b00, digit_en_a}, 8'h00);
        chk("reset_phase_a", {7'b0, blink_phase_a}, 8'h00);
        chk("reset_digits_b", {4'b0, digit_en_b}, 8'h00);

        reset_n = 1'b1;
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        chk("release_a", {2'b00, digit_en_a}, 8'h3f);
        chk("release_b", {4'b0, digit_en_b}, 8'h0f);

        mode_a = 6'b00_01_00;
        repeat (4) pulse();
        chk("slow_dark", {2'b00, digit_en_a}, 8'h33);
        chk("slow_dark_phase", {7'b0, blink_phase_a}, 8'h00);
        repeat (2) pulse();
        chk("ph6_dark", {2'b00, digit_en_a}, 8'h33);
        cyc(1'b1, 1'b1);
        chk("kick_cycle", {2'b00, digit_en_a}, 8'h33);
        cyc(1'b0, 1'b0);
        chk("kick_visible", {2'b00, digit_en_a}, 8'h3f);
        repeat (3) pulse();
        chk("after_kick_ph3", {2'b00, digit_en_a}, 8'h3f);
        pulse();
        chk("after_kick_ph4", {2'b00, digit_en_a}, 8'h33);

        mode_a = 6'b00_00_11;
        cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
`ifdef BLINK_ENGINE_FAST_MODE_EN
        chk("fast_ph2", {2'b00, digit_en_a}, 8'h3c);
`else
        chk("fast_ph2", {2'b00, digit_en_a}, 8'h3f);
`endif
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
`ifdef BLINK_ENGINE_FAST_MODE_EN
        chk("fast_ph4", {2'b00, digit_en_a}, 8'h3f);
`else
        chk("fast_ph4", {2'b00, digit_en_a}, 8'h3c);
`endif

        mode_a = 6'b10_01_00;
        cyc(1'b0, 1'b1);
        repeat (5) cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        chk("mixed_ph5", {2'b00, digit_en_a}, 8'h03);
        mode_a = 6'b00_00_00;
        cyc(1'b0, 1'b0);
        chk("mode_change", {2'b00, digit_en_a}, 8'h3f);

        cyc(1'b0, 1'b1);
        repeat (3) cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        mode_a = 6'b00_01_00;
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_a", {2'b00, digit_en_a}, 8'h00);
        chk("async_reset_phase", {7'b0, blink_phase_a}, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        chk("restart_a", {2'b00, digit_en_a}, 8'h3f);
        chk("restart_b", {4'b0, digit_en_b}, 8'h00);

        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 7) == 0) mode_a = 6'($urandom);
            if ($urandom_range(0, 7) == 0) mode_b = 8'($urandom);
            reset_n = ($urandom_range(0, 199) != 0);
            cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
        end
        reset_n = 1'b1;
        repeat (2) cyc(1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
